// File: rtl/ddr2_port_arb_pkg.sv
// Shared types for the DDR2 local-port arbiter: FSM state, read tag,
// and the round-robin selection helper used by the command arbiter.
package ddr2_port_arb_pkg;

    localparam int MAX_PORTS  = 8;
    localparam int MAX_PORT_W = 3;
    localparam int MAX_SIZE_W = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } arb_state_t;

    // One entry per accepted read: who asked and how many beats to return.
    typedef struct packed {
        logic [MAX_PORT_W-1:0] port;
        logic [MAX_SIZE_W-1:0] size;
    } tag_t;

    // Returns {found, index}: first set bit of elig at or after ptr,
    // wrapping modulo n. Lower offsets are assigned last so they win.
    function automatic logic [MAX_PORT_W:0] rr_pick(
        input logic [MAX_PORTS-1:0]  elig,
        input logic [MAX_PORT_W-1:0] ptr,
        input int                    n
    );
        logic [MAX_PORT_W:0] res;
        int idx;
        res = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && elig[idx[MAX_PORT_W-1:0]])
                res = {1'b1, idx[MAX_PORT_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ddr2_tag_fifo.sv
// Outstanding-read tag FIFO: push at tail, head visible combinationally.
// Ports: clk, rst_n, push/din, pop, head, full, empty.
module ddr2_tag_fifo
    import ddr2_port_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  tag_t din,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    tag_t         mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ddr2_local_port_arbiter.sv
// N-client front end for the DDR2 local interface: round-robin command
// arbitration, atomic write bursts and tag-steered read-return beats.
// Ports: phy_clk, reset_phy_clk_n; p_* client ports; local_* controller
// port; err_orphan_rdata (sticky read beat with no outstanding tag).
module ddr2_local_port_arbiter
    import ddr2_port_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 24,
    parameter int SIZE_W    = 4,
    parameter int TAG_DEPTH = 16,
    parameter int BE_W      = DATA_W / 8
) (
    input  logic                          phy_clk,
    input  logic                          reset_phy_clk_n,
    input  logic [NUM_PORTS-1:0]          p_read_req,
    input  logic [NUM_PORTS-1:0]          p_write_req,
    input  logic [NUM_PORTS-1:0]          p_burstbegin,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr,
    input  logic [NUM_PORTS*SIZE_W-1:0]   p_size,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata,
    input  logic [NUM_PORTS*BE_W-1:0]     p_be,
    output logic [NUM_PORTS-1:0]          p_ready,
    output logic [DATA_W-1:0]             p_rdata,
    output logic [NUM_PORTS-1:0]          p_rdata_valid,
    output logic                          local_read_req,
    output logic                          local_write_req,
    output logic                          local_burstbegin,
    output logic [ADDR_W-1:0]             local_address,
    output logic [SIZE_W-1:0]             local_size,
    output logic [DATA_W-1:0]             local_wdata,
    output logic [BE_W-1:0]               local_be,
    input  logic                          local_ready,
    input  logic                          local_rdata_valid,
    input  logic                          local_init_done,
    input  logic [DATA_W-1:0]             local_rdata,
    output logic                          err_orphan_rdata
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t           state, state_nxt;
    logic [PW-1:0]        rr_ptr, rr_nxt;
    logic [PW-1:0]        grant_q, grant_nxt;
    logic [PW-1:0]        g;
    logic [SIZE_W-1:0]    beats_left, beats_nxt;
    logic [SIZE_W-1:0]    rd_cnt;
    logic [SIZE_W-1:0]    req_size;
    logic [NUM_PORTS-1:0] wr_ok, rd_ok, elig;
    logic [MAX_PORT_W:0]  pick;
    logic                 found;
    logic                 tag_push, tag_pop;
    logic                 tag_full, tag_empty;
    tag_t                 tag_in, tag_head;

    logic [ADDR_W-1:0]    addr_a  [NUM_PORTS];
    logic [SIZE_W-1:0]    size_a  [NUM_PORTS];
    logic [DATA_W-1:0]    wdata_a [NUM_PORTS];
    logic [BE_W-1:0]      be_a    [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign addr_a[i]  = p_addr[i*ADDR_W +: ADDR_W];
        assign size_a[i]  = p_size[i*SIZE_W +: SIZE_W];
        assign wdata_a[i] = p_wdata[i*DATA_W +: DATA_W];
        assign be_a[i]    = p_be[i*BE_W +: BE_W];
    end

    function automatic logic [PW-1:0] inc_port(input logic [PW-1:0] p);
        return (p == PW'(NUM_PORTS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Write wins over read; reads wait while the tag FIFO is full
    // (registered flag, so a same-cycle pop does not help).
    assign wr_ok = p_burstbegin & p_write_req;
    assign rd_ok = p_burstbegin & p_read_req & ~p_write_req &
                   {NUM_PORTS{~tag_full}};
    assign elig  = wr_ok | rd_ok;

    assign pick  = rr_pick(MAX_PORTS'(elig), MAX_PORT_W'(rr_ptr),
                           NUM_PORTS);
    assign found = pick[MAX_PORT_W];
    assign g     = PW'(pick[MAX_PORT_W-1:0]);

    assign req_size = (size_a[g] == '0) ? SIZE_W'(1) : size_a[g];

    always_comb begin
        state_nxt        = state;
        rr_nxt           = rr_ptr;
        grant_nxt        = grant_q;
        beats_nxt        = beats_left;
        p_ready          = '0;
        local_read_req   = 1'b0;
        local_write_req  = 1'b0;
        local_burstbegin = 1'b0;
        local_address    = '0;
        local_size       = '0;
        local_wdata      = '0;
        local_be         = '0;
        tag_push         = 1'b0;
        tag_in           = '0;
        if (local_init_done) begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        local_burstbegin = 1'b1;
                        local_write_req  = p_write_req[g];
                        local_read_req   = ~p_write_req[g];
                        local_address    = addr_a[g];
                        local_size       = size_a[g];
                        local_wdata      = wdata_a[g];
                        local_be         = be_a[g];
                        p_ready[g]       = local_ready;
                        tag_in.port      = MAX_PORT_W'(g);
                        tag_in.size      = MAX_SIZE_W'(req_size);
                        if (local_ready) begin
                            if (!p_write_req[g]) begin
                                tag_push = 1'b1;
                                rr_nxt   = inc_port(g);
                            end else if (req_size == SIZE_W'(1)) begin
                                rr_nxt = inc_port(g);
                            end else begin
                                grant_nxt = g;
                                beats_nxt = req_size - SIZE_W'(1);
                                state_nxt = WBURST;
                            end
                        end
                    end
                end
                WBURST: begin
                    local_write_req  = p_write_req[grant_q];
                    local_address    = addr_a[grant_q];
                    local_size       = size_a[grant_q];
                    local_wdata      = wdata_a[grant_q];
                    local_be         = be_a[grant_q];
                    p_ready[grant_q] = local_ready;
                    if (p_write_req[grant_q] && local_ready) begin
                        beats_nxt = beats_left - SIZE_W'(1);
                        if (beats_left == SIZE_W'(1)) begin
                            state_nxt = IDLE;
                            rr_nxt    = inc_port(grant_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data is broadcast; only the head tag's port sees valid.
    assign p_rdata = local_rdata;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            p_rdata_valid[i] = local_rdata_valid & ~tag_empty &
                               (tag_head.port == MAX_PORT_W'(i));
    end

    assign tag_pop = local_rdata_valid & ~tag_empty &
                     ((MAX_SIZE_W'(rd_cnt) + MAX_SIZE_W'(1))
                      == tag_head.size);

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant_q          <= '0;
            beats_left       <= '0;
            rd_cnt           <= '0;
            err_orphan_rdata <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            grant_q    <= grant_nxt;
            beats_left <= beats_nxt;
            if (local_rdata_valid) begin
                if (tag_empty)    err_orphan_rdata <= 1'b1;
                else if (tag_pop) rd_cnt <= '0;
                else              rd_cnt <= rd_cnt + SIZE_W'(1);
            end
        end
    end

    ddr2_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (phy_clk),
        .rst_n (reset_phy_clk_n),
        .push  (tag_push),
        .din   (tag_in),
        .pop   (tag_pop),
        .head  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule
